// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX-stage control and muldiv_unit.
//   master : EX control   -- drives start/op/a/b/flush/hi_we/lo_we/hilo_wdata
//                           and receives busy/done/hi/lo
//   slave  : muldiv_unit  -- the mirror image of master
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hilo_wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, hilo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, hilo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : muldiv_if.slave
//                start/op/a/b -> issue an op (accepted only when idle and not flushed)
//                flush        -> abort the in-flight op; hi/lo are left untouched
//                hi_we/lo_we  -> MTHI/MTLO using hilo_wdata, honoured only while idle
//                busy         -> op in flight, so EX must stall
//                done         -> one-cycle pulse, raised once hi/lo hold the new result
//                hi/lo        -> architectural HI/LO registers
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// The core works on magnitudes; signs are applied in the FIX state.
// Latency from start to done is WIDTH+2 cycles.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier and go
// straight from IDLE to FIX, so done comes 2 cycles after start. Divides are unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;     // |multiplicand|
  logic [WIDTH-1:0] opb;     // |divisor|
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] q;       // multiplier (shifted out) -> product low half; dividend -> quotient
  logic             op_div;
  logic             neg_q;   // negate product / quotient
  logic             neg_r;   // negate remainder (sign of dividend)
  logic             div0;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Operand capture. 0x80000000 negates to itself, which is the correct unsigned magnitude.
  logic             sgn;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             issue;

  assign sgn   = ~bus.op[0];
  assign mag_a = (sgn && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b = (sgn && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign issue = bus.start && !bus.flush;

  // Shift-add multiply step: add the multiplicand when the current multiplier
  // bit is set. The carry, the sum and the multiplier are then shifted right as
  // one 2*WIDTH+1-bit value.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc} + ({(WIDTH+1){q[0]}} & {1'b0, opa});

  // Restoring divide step: shift the next dividend bit into the remainder, then
  // subtract if that does not go negative.
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};

  // Result formation for the FIX state.
  logic [2*WIDTH-1:0] raw_prod;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_FAST_MUL_EN
  assign raw_prod = opa * opb;
`else
  assign raw_prod = {acc, q};
`endif

  always_comb begin
    prod   = neg_q ? (~raw_prod + 1'b1) : raw_prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div) begin
      // A zero divisor leaves quotient=all ones and remainder=|a|, so hi comes out
      // as a once the sign is restored. lo is forced so the quotient sign never flips it.
      res_hi = neg_r ? (~acc + 1'b1) : acc;
      res_lo = div0 ? {WIDTH{1'b1}} : (neg_q ? (~q + 1'b1) : q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      q      <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.hi_we) hi_r <= bus.hilo_wdata;
          if (bus.lo_we) lo_r <= bus.hilo_wdata;
          if (issue) begin
            opa    <= mag_a;
            opb    <= mag_b;
            op_div <= bus.op[1];
            neg_q  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= sgn & bus.a[WIDTH-1];
            div0   <= (bus.b == '0);
            acc    <= '0;
            q      <= bus.op[1] ? mag_a : mag_b;
            cnt    <= CW'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
            state  <= bus.op[1] ? S_RUN : S_FIX;
`else
            state  <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            if (op_div) begin
              if (!div_diff[WIDTH]) begin
                acc <= div_diff[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b1};
              end else begin
                acc <= div_sh[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= mul_sum[WIDTH:1];
              q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
            cnt <= cnt - 1'b1;
            // This is the last iteration: the counter reaches 0 on this edge.
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!bus.flush) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            done_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // The start pulse is high over one rising edge ("cycle 0"). On return the
  // bench sits at the falling edge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = xa; bus.b = xb;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input int lat_exp,
                        input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int lat;
    issue(o, xa, xb);
    lat = 1;
    chk({tag, "_busy"}, 64'(bus.busy), 64'(lat_exp > 1));
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},  64'(lat),      64'(lat_exp));
    chk({tag, "_hi"},   64'(bus.hi),   64'(hi_exp));
    chk({tag, "_lo"},   64'(bus.lo),   64'(lo_exp));
    chk({tag, "_bsy0"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done1"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hilo_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    // main function
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFA, 32'd7,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_0",    2'b11, 32'd7,        32'd0,        DIV_LAT, 32'd7,        32'hFFFFFFFF);
    run_op("div_0",     2'b10, 32'hFFFFFFF9, 32'd0,        DIV_LAT, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu_100",  2'b11, 32'd100,      32'd3,        DIV_LAT, 32'd1,        32'd33);

    // DIV overflow case, plus a second start while busy that must be ignored
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chk("ovf_dones", 64'(dones), 64'd1);
    chk("ovf_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);

    // MTHI/MTLO while idle
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mthi_mtlo", {bus.hi, bus.lo}, 64'h00001234_00005678);

    // flush mid-op; an MTHI while busy must be ignored as well
    issue(2'b11, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'hBEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    repeat (6) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chk("flush_done", 64'(dones), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h00001234_00005678);

    // start and flush in the same cycle: nothing is issued
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("stflush_busy", 64'(bus.busy), 64'd0);

    // start together with MTHI: the write lands now, and the op result overwrites it later
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7;
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'hCAFE;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("sthi_hi", 64'(bus.hi), 64'h0000CAFE);
    for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
    chk("sthi_res", {bus.hi, bus.lo}, 64'd42);

    // asynchronous reset in the middle of an op
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b01, 32'd3, 32'd5, MUL_LAT, 32'd0, 32'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
